// File: rtl/sprite_draw_pipeline.sv
// Two-stage pixel pipeline drawing one bouncing bordered square sprite
// over a solid background, delay-matched with the sync/data-enable path.
module sprite_draw_pipeline #(
    parameter int          COORDINATE_WIDTH = 10,
    parameter int          H_ACTIVE         = 640,
    parameter int          V_ACTIVE         = 480,
    parameter int          SPRITE_SIZE      = 32,
    parameter int          STEP             = 2,
    parameter int          START_X          = 304,
    parameter int          START_Y          = 224,
    parameter logic [11:0] BG_COLOR         = 12'h113,
    parameter logic [11:0] FILL_COLOR       = 12'hF80,
    parameter logic [11:0] BORDER_COLOR     = 12'hFFF,
    parameter logic        SYNC_RESET_LEVEL = 1'b1
) (
    input  logic                        clk,
    input  logic                        pixel_reset,
    input  logic                        horiz_sync_in,
    input  logic                        vert_sync_in,
    input  logic                        data_enable_in,
    input  logic [COORDINATE_WIDTH-1:0] horiz_pos,
    input  logic [COORDINATE_WIDTH-1:0] vert_pos,
    input  logic                        move_en,
    output logic                        horiz_sync_out,
    output logic                        vert_sync_out,
    output logic                        data_enable_out,
    output logic [3:0]                  red,
    output logic [3:0]                  green,
    output logic [3:0]                  blue,
    output logic [COORDINATE_WIDTH-1:0] sprite_x,
    output logic [COORDINATE_WIDTH-1:0] sprite_y
);

    localparam int CW = COORDINATE_WIDTH;

    typedef logic [CW:0] ext_t;

    localparam ext_t          L_LAST   = ext_t'(SPRITE_SIZE - 1);
    localparam ext_t          L_STEP   = ext_t'(STEP);
    localparam ext_t          L_MAX_X  = ext_t'(H_ACTIVE - SPRITE_SIZE);
    localparam ext_t          L_MAX_Y  = ext_t'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [CW-1:0] L_TICK_H = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] L_TICK_V = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] L_STEP_C = CW'(STEP);

    // Returns {dir_negative, position} after one bounce-aware step.
    function automatic logic [CW:0] f_step(
        input logic [CW-1:0] pos,
        input logic          neg,
        input ext_t          max
    );
        ext_t pos_ext;
        pos_ext = {1'b0, pos};
        if (!neg) begin
            if (pos_ext + L_STEP >= max)
                return {1'b1, max[CW-1:0]};
            return {1'b0, pos + L_STEP_C};
        end
        if (pos_ext <= L_STEP)
            return {1'b0, {CW{1'b0}}};
        return {1'b1, pos - L_STEP_C};
    endfunction

    logic [CW-1:0] r_sprite_x;
    logic [CW-1:0] r_sprite_y;
    logic          r_dir_x_neg;
    logic          r_dir_y_neg;

    logic          r_hs1;
    logic          r_vs1;
    logic          r_de1;
    logic          r_in_box1;
    logic          r_on_border1;

    logic          r_hs2;
    logic          r_vs2;
    logic          r_de2;
    logic [11:0]   r_rgb;

    ext_t          w_h;
    ext_t          w_v;
    ext_t          w_x;
    ext_t          w_y;
    ext_t          w_x_end;
    ext_t          w_y_end;
    logic          w_in_x;
    logic          w_in_y;
    logic          w_in_box;
    logic          w_on_border;
    logic          w_tick;
    logic          w_move;
    logic [CW:0]   w_step_x;
    logic [CW:0]   w_step_y;
    logic [11:0]   w_rgb;

    // Extended widths keep sprite_x+SPRITE_SIZE-1 from wrapping.
    assign w_h     = {1'b0, horiz_pos};
    assign w_v     = {1'b0, vert_pos};
    assign w_x     = {1'b0, r_sprite_x};
    assign w_y     = {1'b0, r_sprite_y};
    assign w_x_end = w_x + L_LAST;
    assign w_y_end = w_y + L_LAST;

    assign w_in_x   = (w_h >= w_x) && (w_h <= w_x_end);
    assign w_in_y   = (w_v >= w_y) && (w_v <= w_y_end);
    assign w_in_box = w_in_x && w_in_y;

    assign w_on_border = w_in_box &&
                         ((w_h == w_x) || (w_h == w_x_end) ||
                          (w_v == w_y) || (w_v == w_y_end));

    assign w_tick = data_enable_in &&
                    (horiz_pos == L_TICK_H) &&
                    (vert_pos == L_TICK_V);
    assign w_move = w_tick && move_en;

    assign w_step_x = f_step(r_sprite_x, r_dir_x_neg, L_MAX_X);
    assign w_step_y = f_step(r_sprite_y, r_dir_y_neg, L_MAX_Y);

    always_comb begin
        w_rgb = BG_COLOR;
        if (!r_de1)
            w_rgb = 12'h000;
        else if (r_on_border1)
            w_rgb = BORDER_COLOR;
        else if (r_in_box1)
            w_rgb = FILL_COLOR;
    end

    // The tick pixel is compared against the old position in stage 1
    // while the position registers update at the same edge.
    always_ff @(posedge clk or posedge pixel_reset) begin
        if (pixel_reset) begin
            r_sprite_x  <= CW'(START_X);
            r_sprite_y  <= CW'(START_Y);
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
        end else if (w_move) begin
            {r_dir_x_neg, r_sprite_x} <= w_step_x;
            {r_dir_y_neg, r_sprite_y} <= w_step_y;
        end
    end

    always_ff @(posedge clk or posedge pixel_reset) begin
        if (pixel_reset) begin
            r_hs1        <= SYNC_RESET_LEVEL;
            r_vs1        <= SYNC_RESET_LEVEL;
            r_de1        <= 1'b0;
            r_in_box1    <= 1'b0;
            r_on_border1 <= 1'b0;
        end else begin
            r_hs1        <= horiz_sync_in;
            r_vs1        <= vert_sync_in;
            r_de1        <= data_enable_in;
            r_in_box1    <= w_in_box;
            r_on_border1 <= w_on_border;
        end
    end

    always_ff @(posedge clk or posedge pixel_reset) begin
        if (pixel_reset) begin
            r_hs2 <= SYNC_RESET_LEVEL;
            r_vs2 <= SYNC_RESET_LEVEL;
            r_de2 <= 1'b0;
            r_rgb <= 12'h000;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de2 <= r_de1;
            r_rgb <= w_rgb;
        end
    end

    assign horiz_sync_out  = r_hs2;
    assign vert_sync_out   = r_vs2;
    assign data_enable_out = r_de2;
    assign red             = r_rgb[11:8];
    assign green           = r_rgb[7:4];
    assign blue            = r_rgb[3:0];
    assign sprite_x        = r_sprite_x;
    assign sprite_y        = r_sprite_y;

endmodule

// File: tb/tb_sprite_draw_pipeline.sv
// Bench for sprite_draw_pipeline: vector table, hand sequences for reset and
// bounce, then randomized traffic against an integer reference model.
module tb_sprite_draw_pipeline;

    localparam int SZ    = 32;
    localparam int STP   = 2;
    localparam int MAX_X = 640 - SZ;
    localparam int MAX_Y = 480 - SZ;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs_i, vs_i, de_i, me;
    logic [9:0] h_i, v_i;
    logic       hs_o, vs_o, de_o;
    logic [3:0] r_o, g_o, b_o;
    logic [9:0] sx, sy;

    always #5 clk = ~clk;

    sprite_draw_pipeline dut (
        .clk             (clk),
        .pixel_reset     (rst),
        .horiz_sync_in   (hs_i),
        .vert_sync_in    (vs_i),
        .data_enable_in  (de_i),
        .horiz_pos       (h_i),
        .vert_pos        (v_i),
        .move_en         (me),
        .horiz_sync_out  (hs_o),
        .vert_sync_out   (vs_o),
        .data_enable_out (de_o),
        .red             (r_o),
        .green           (g_o),
        .blue            (b_o),
        .sprite_x        (sx),
        .sprite_y        (sy)
    );

    typedef struct {
        int          h;
        int          v;
        bit          de;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        bit          hs;
        bit          vs;
        bit          de;
        logic [11:0] rgb;
    } exp_t;

    int tests = 0;
    int fails = 0;

    int mx, my;
    bit mnx, mny;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit hs, input bit vs, input bit de,
                         input int h, input int v, input bit m);
        hs_i = hs;
        vs_i = vs;
        de_i = de;
        h_i  = 10'(h);
        v_i  = 10'(v);
        me   = m;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick(input bit m);
        drive(0, 0, 1, 639, 479, m);
    endtask

    function automatic logic [11:0] rgb_now();
        return {r_o, g_o, b_o};
    endfunction

    task automatic model_reset();
        mx  = 304;
        my  = 224;
        mnx = 0;
        mny = 0;
    endtask

    task automatic axis_move(inout int p, inout bit neg, input int lim);
        if (!neg) begin
            if (p + STP >= lim) begin
                p   = lim;
                neg = 1;
            end else begin
                p = p + STP;
            end
        end else begin
            if (p <= STP) begin
                p   = 0;
                neg = 0;
            end else begin
                p = p - STP;
            end
        end
    endtask

    task automatic model_tick();
        axis_move(mx, mnx, MAX_X);
        axis_move(my, mny, MAX_Y);
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v,
                                              input bit de, input int x,
                                              input int y);
        bit inside_box, edge_px;
        if (!de)
            return 12'h000;
        inside_box = (h >= x) && (h < x + SZ) && (v >= y) && (v < y + SZ);
        edge_px = (h == x) || (h == x + SZ - 1) ||
                  (v == y) || (v == y + SZ - 1);
        if (inside_box && edge_px)
            return 12'hFFF;
        if (inside_box)
            return 12'hF80;
        return 12'h113;
    endfunction

    vec_t vecs [0:9];
    exp_t q[$];

    initial begin
        vecs[0] = '{304, 224, 1'b1, 12'hFFF};
        vecs[1] = '{305, 225, 1'b1, 12'hF80};
        vecs[2] = '{303, 224, 1'b1, 12'h113};
        vecs[3] = '{335, 255, 1'b1, 12'hFFF};
        vecs[4] = '{336, 240, 1'b1, 12'h113};
        vecs[5] = '{310, 230, 1'b0, 12'h000};
        vecs[6] = '{320, 256, 1'b1, 12'h113};
        vecs[7] = '{335, 240, 1'b1, 12'hFFF};
        vecs[8] = '{320, 240, 1'b1, 12'hF80};
        vecs[9] = '{304, 255, 1'b1, 12'hFFF};

        rst = 1'b1;
        idle();
        cyc();
        cyc();
        check("rst_rgb", rgb_now(), 12'h000);
        check("rst_de", de_o, 0);
        check("rst_hs", hs_o, 1);
        check("rst_vs", vs_o, 1);
        check("rst_x", sx, 304);
        check("rst_y", sy, 224);
        #2 rst = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            drive(0, 0, vecs[i].de, vecs[i].h, vecs[i].v, 0);
            cyc();
            check($sformatf("lat1_de_%0d", i), de_o, 0);
            idle();
            cyc();
            check($sformatf("vec_rgb_%0d", i), rgb_now(), vecs[i].rgb);
            check($sformatf("vec_de_%0d", i), de_o, vecs[i].de);
        end

        tick(1);
        cyc();
        check("move_x", sx, 306);
        check("move_y", sy, 226);
        idle();
        cyc();
        check("tick_px_rgb", rgb_now(), 12'h113);
        drive(0, 0, 1, 304, 224, 0);
        cyc();
        idle();
        cyc();
        check("old_corner_rgb", rgb_now(), 12'h113);
        drive(0, 0, 1, 306, 226, 0);
        cyc();
        idle();
        cyc();
        check("new_corner_rgb", rgb_now(), 12'hFFF);
        tick(0);
        cyc();
        check("hold_x", sx, 306);
        check("hold_y", sy, 226);
        drive(0, 0, 1, 639, 478, 1);
        cyc();
        check("notick_x", sx, 306);
        drive(0, 0, 0, 639, 479, 1);
        cyc();
        check("de0_tick_y", sy, 226);

        drive(1, 0, 1, 306, 226, 0);
        cyc();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rgb", rgb_now(), 12'h000);
        check("mid_rst_de", de_o, 0);
        check("mid_rst_hs", hs_o, 1);
        check("mid_rst_vs", vs_o, 1);
        check("mid_rst_x", sx, 304);
        check("mid_rst_y", sy, 224);
        cyc();
        check("rst_hold_de", de_o, 0);
        check("rst_hold_rgb", rgb_now(), 12'h000);
        #2 rst = 1'b0;
        model_reset();
        drive(0, 1, 1, 304, 224, 0);
        cyc();
        check("post_rst1_de", de_o, 0);
        check("post_rst1_hs", hs_o, 1);
        idle();
        cyc();
        check("post_rst2_rgb", rgb_now(), 12'hFFF);
        check("post_rst2_de", de_o, 1);
        check("post_rst2_hs", hs_o, 0);
        check("post_rst2_vs", vs_o, 1);

        for (int k = 1; k <= 460; k++) begin
            int ox, oy;
            ox = mx;
            oy = my;
            tick(1);
            cyc();
            model_tick();
            check($sformatf("bounce_x_%0d", k), sx, mx);
            check($sformatf("bounce_y_%0d", k), sy, my);
            if (k == 112) check("edge_y_max", sy, 448);
            if (k == 113) check("edge_y_back", sy, 446);
            if (k == 152) check("edge_x_max", sx, 608);
            if (k == 153) check("edge_x_back", sx, 606);
            if (k == 456) check("edge_x_zero", sx, 0);
            if (k == 457) check("edge_x_fwd", sx, 2);
            idle();
            cyc();
            check($sformatf("tick_rgb_%0d", k), rgb_now(),
                  model_rgb(639, 479, 1, ox, oy));
        end

        for (int i = 0; i < 4000; i++) begin
            exp_t e;
            bit   hs, vs, de, m;
            int   h, v;
            hs = 1'($urandom);
            vs = 1'($urandom);
            de = 1'($urandom);
            m  = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                h = (mx + int'($urandom_range(0, SZ + 3)) - 2) & 1023;
                v = (my + int'($urandom_range(0, SZ + 3)) - 2) & 1023;
            end else begin
                h = int'($urandom_range(0, 1023));
                v = int'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 39) == 0) begin
                de = 1;
                h  = 639;
                v  = 479;
            end
            e.hs  = hs;
            e.vs  = vs;
            e.de  = de;
            e.rgb = model_rgb(h, v, de, mx, my);
            q.push_back(e);
            drive(hs, vs, de, h, v, m);
            if (de && h == 639 && v == 479 && m)
                model_tick();
            cyc();
            check("rnd_x", sx, mx);
            check("rnd_y", sy, my);
            if (q.size() == 2) begin
                e = q.pop_front();
                check("rnd_hs", hs_o, e.hs);
                check("rnd_vs", vs_o, e.vs);
                check("rnd_de", de_o, e.de);
                check("rnd_rgb", rgb_now(), e.rgb);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_draw_pipeline.md
Name: sprite_draw_pipeline

Overview:
- Pixel-pipeline stage directly downstream of the display timing generator.
- Consumes its horiz_sync, vert_sync, data_enable, horiz_pos and vert_pos outputs, and draws one moving bordered square sprite over a solid background.
- Emits RGB plus sync and data-enable signals, delay-matched to the video output pins.
- The sprite bounces off the active-area edges and moves once per frame.

Parameters:
- COORDINATE_WIDTH, 10, width of horiz_pos/vert_pos and sprite coordinates.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SPRITE_SIZE, 32, sprite edge length in pixels (square, >=3).
- STEP, 2, pixels moved per axis per frame (1..SPRITE_SIZE).
- START_X, 304, sprite left edge after reset.
- START_Y, 224, sprite top edge after reset.
- BG_COLOR, 12'h113, background {R,G,B} 4 bits each.
- FILL_COLOR, 12'hF80, sprite interior colour.
- BORDER_COLOR, 12'hFFF, sprite 1-pixel border colour.
- SYNC_RESET_LEVEL, 1, value driven on sync outputs during reset.

Ports:
- clk  in  1  pixel clock.
- pixel_reset  in  1  reset, asynchronous, active-high.
- horiz_sync_in  in  1  from timing generator.
- vert_sync_in  in  1  from timing generator.
- data_enable_in  in  1  high during active pixels.
- horiz_pos  in  COORDINATE_WIDTH  current pixel column.
- vert_pos  in  COORDINATE_WIDTH  current line.
- move_en  in  1  1 = sprite advances at frame tick.
- horiz_sync_out  out  1  horiz_sync_in delayed 2 cycles.
- vert_sync_out  out  1  vert_sync_in delayed 2 cycles.
- data_enable_out  out  1  data_enable_in delayed 2 cycles.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.
- sprite_x  out  COORDINATE_WIDTH  current sprite left edge.
- sprite_y  out  COORDINATE_WIDTH  current sprite top edge.

Behaviour:
- Reset: pixel_reset asserted asynchronously forces the following, and they hold while asserted:
  - red, green and blue = 0.
  - data_enable_out = 0.
  - both sync outputs = SYNC_RESET_LEVEL.
  - all pipeline registers cleared, with stage-1 syncs = SYNC_RESET_LEVEL.
  - sprite_x = START_X, sprite_y = START_Y.
  - direction flags dir_x = dir_y = positive.
- Reset mid-frame behaves identically; no partial pixel is emitted afterward.
- Pipeline, fixed latency 2 cycles for all outputs:
  - Stage 1 registers the syncs and data_enable_in.
  - Stage 1 also registers the flags in_box and on_border.
  - in_box = horiz_pos in [sprite_x, sprite_x+SPRITE_SIZE-1] and vert_pos in [sprite_y, sprite_y+SPRITE_SIZE-1].
  - on_border = in_box and (local x or local y equals 0 or SPRITE_SIZE-1).
  - Stage 2 registers the outputs and colour.
- Colour at stage 2:
  - if stage-1 data_enable = 0: RGB = 0.
  - else if on_border: BORDER_COLOR.
  - else if in_box: FILL_COLOR.
  - else: BG_COLOR.
- Comparisons are computed at COORDINATE_WIDTH+1 bits so sprite_x+SPRITE_SIZE-1 never wraps.
- Frame tick: a single cycle where data_enable_in=1, horiz_pos=H_ACTIVE-1 and vert_pos=V_ACTIVE-1.
  - That pixel is drawn with the pre-update position; the update takes effect at the same clock edge.
  - The position never changes inside an active frame.
- Motion: on frame tick with move_en=1, each axis is updated independently. X axis, with MAX = H_ACTIVE-SPRITE_SIZE:
  - dir positive, sprite_x+STEP >= MAX: sprite_x = MAX, dir_x = negative.
  - dir negative, sprite_x <= STEP: sprite_x = 0, dir_x = positive.
  - otherwise: sprite_x ± STEP.
- Y axis follows the same rules, using V_ACTIVE and dir_y.
- move_en=0 at the tick leaves position and direction unchanged. move_en is ignored outside the tick.
- Sync outputs are pure delays; polarity is not interpreted.
- Position inputs outside the active area are legal; the colour result is masked by data_enable.

Test Plan:
- Reset check: assert pixel_reset between clock edges mid-frame -> immediately RGB=000, data_enable_out=0, syncs=1, sprite_x=304, sprite_y=224; after release the first output follows input 2 cycles later.
- Colour and latency: drive de=1 with (h,v)=(304,224) at cycle N -> RGB=FFF at N+2.
  - (305,225) -> F80.
  - (303,224) -> 113.
  - (335,255) -> FFF.
  - (336,240) -> 113.
- Blanking mask: de=0 with (h,v)=(310,230) -> RGB=000 two cycles later; data_enable_out=0.
- Motion: with move_en=1, one tick -> sprite (306,226). With move_en=0, next tick -> unchanged. Pixel (304,224) on the tick cycle itself still uses the old position.
- Bounce:
  - X edge: preload via ticks to sprite_x=606 moving +, tick -> 608 and dir negative; next tick -> 606.
  - Y edge: sprite_y reaching 448 reverses the same way.
  - Left edge: sprite_x=1 moving -, tick -> 0; next tick -> 2.
- Sync passthrough: random hsync/vsync/de pattern -> outputs equal inputs exactly 2 cycles later, every cycle, over two full frames.
